// File: rtl/dmem_arbiter.sv
// Two-port arbiter/sequencer in front of the 256x64 data memory.
// Port A (CPU) has priority; port B (debug/DMA) is forced after MAX_CONSEC A wins.
module dmem_arbiter #(
    parameter int ADDR_W     = 48,
    parameter int DATA_W     = 64,
    parameter int MEM_WORDS  = 256,
    parameter int MAX_CONSEC = 4
) (
    input  logic              clk,
    input  logic              rst_n,

    input  logic              a_req,
    input  logic              a_we,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [DATA_W-1:0] a_wdata,
    output logic              a_gnt,
    output logic              a_rvalid,
    output logic [DATA_W-1:0] a_rdata,
    output logic              a_err,

    input  logic              b_req,
    input  logic              b_we,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [DATA_W-1:0] b_wdata,
    output logic              b_gnt,
    output logic              b_rvalid,
    output logic [DATA_W-1:0] b_rdata,
    output logic              b_err,

    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_write_data,
    output logic              mem_write,
    output logic              mem_read,
    input  logic [DATA_W-1:0] mem_read_data
);

    localparam logic [ADDR_W-1:0] ADDR_LIMIT = ADDR_W'(MEM_WORDS);
    localparam logic [3:0]        CONS_MAX   = 4'(MAX_CONSEC);

    typedef enum logic [1:0] {
        OWN_NONE,
        OWN_A,
        OWN_B
    } owner_t;

    owner_t      r_owner;
    owner_t      w_owner_nxt;
    logic [3:0]  r_cons;
    logic        r_a_err;
    logic        r_b_err;
    logic        r_rd_oor;

    logic        w_a_gnt;
    logic        w_b_gnt;
    logic        w_a_inr;
    logic        w_b_inr;
    logic        w_a_issue;
    logic        w_b_issue;

    assign w_a_inr = (a_addr < ADDR_LIMIT);
    assign w_b_inr = (b_addr < ADDR_LIMIT);

    // B is only ever blocked by A, and A only yields when its streak hit the limit
    assign w_a_gnt   = rst_n & a_req & ~(b_req & (r_cons == CONS_MAX));
    assign w_b_gnt   = rst_n & b_req & ~w_a_gnt;
    assign w_a_issue = w_a_gnt & w_a_inr;
    assign w_b_issue = w_b_gnt & w_b_inr;

    assign a_gnt = w_a_gnt;
    assign b_gnt = w_b_gnt;

    always_comb begin
        mem_address    = '0;
        mem_write_data = '0;
        mem_write      = 1'b0;
        mem_read       = 1'b0;
        if (w_a_issue) begin
            mem_address    = a_addr;
            mem_write_data = a_wdata;
            mem_write      = a_we;
            mem_read       = ~a_we;
        end else if (w_b_issue) begin
            mem_address    = b_addr;
            mem_write_data = b_wdata;
            mem_write      = b_we;
            mem_read       = ~b_we;
        end
    end

    always_comb begin
        w_owner_nxt = OWN_NONE;
        if (w_a_gnt && !a_we) begin
            w_owner_nxt = OWN_A;
        end else if (w_b_gnt && !b_we) begin
            w_owner_nxt = OWN_B;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_owner  <= OWN_NONE;
            r_cons   <= '0;
            r_a_err  <= 1'b0;
            r_b_err  <= 1'b0;
            r_rd_oor <= 1'b0;
        end else begin
            r_owner  <= w_owner_nxt;
            r_a_err  <= w_a_gnt & ~w_a_inr;
            r_b_err  <= w_b_gnt & ~w_b_inr;
            r_rd_oor <= (w_a_gnt & ~a_we & ~w_a_inr) | (w_b_gnt & ~b_we & ~w_b_inr);
            if (w_b_gnt || !b_req) begin
                r_cons <= '0;
            end else if (w_a_gnt && (r_cons != CONS_MAX)) begin
                r_cons <= r_cons + 4'd1;
            end
        end
    end

    assign a_rvalid = (r_owner == OWN_A);
    assign b_rvalid = (r_owner == OWN_B);
    assign a_err    = r_a_err;
    assign b_err    = r_b_err;

    // out-of-range reads return zero since the memory was never accessed
    assign a_rdata = (rst_n && a_rvalid && !r_rd_oor) ? mem_read_data : '0;
    assign b_rdata = (rst_n && b_rvalid && !r_rd_oor) ? mem_read_data : '0;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: directed scenarios then random traffic,
// checked against a transaction-level reference model and a behavioural memory.
module tb_dmem_arbiter;

    localparam int ADDR_W     = 48;
    localparam int DATA_W     = 64;
    localparam int MEM_WORDS  = 256;
    localparam int MAX_CONSEC = 4;

    logic              clk;
    logic              rst_n;
    logic              a_req, a_we, a_gnt, a_rvalid, a_err;
    logic [ADDR_W-1:0] a_addr;
    logic [DATA_W-1:0] a_wdata, a_rdata;
    logic              b_req, b_we, b_gnt, b_rvalid, b_err;
    logic [ADDR_W-1:0] b_addr;
    logic [DATA_W-1:0] b_wdata, b_rdata;
    logic [ADDR_W-1:0] mem_address;
    logic [DATA_W-1:0] mem_write_data, mem_read_data;
    logic              mem_write, mem_read;

    dmem_arbiter #(
        .ADDR_W(ADDR_W),
        .DATA_W(DATA_W),
        .MEM_WORDS(MEM_WORDS),
        .MAX_CONSEC(MAX_CONSEC)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
        .a_gnt(a_gnt), .a_rvalid(a_rvalid), .a_rdata(a_rdata), .a_err(a_err),
        .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
        .b_gnt(b_gnt), .b_rvalid(b_rvalid), .b_rdata(b_rdata), .b_err(b_err),
        .mem_address(mem_address), .mem_write_data(mem_write_data),
        .mem_write(mem_write), .mem_read(mem_read), .mem_read_data(mem_read_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // The data memory the arbiter drives: registered read and write, word = index at start.
    logic [DATA_W-1:0] bus_mem [MEM_WORDS];
    initial begin
        for (int i = 0; i < MEM_WORDS; i++) bus_mem[i] = 64'(i);
        mem_read_data = '0;
        forever begin
            @(posedge clk);
            if (mem_write) bus_mem[mem_address[7:0]] <= mem_write_data;
            if (mem_read)  mem_read_data <= bus_mem[mem_address[7:0]];
        end
    end

    // Reference model state
    logic [DATA_W-1:0] ref_mem [MEM_WORDS];
    int                streak;
    int                n_assert;
    int                n_fail;
    int                b_gnt_seen;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic ar, input logic aw, input logic [ADDR_W-1:0] aa,
                        input logic [DATA_W-1:0] ad,
                        input logic br, input logic bw, input logic [ADDR_W-1:0] ba,
                        input logic [DATA_W-1:0] bd,
                        input logic rst, input logic rst_mid);
        logic              eg_a, eg_b, g_we, inr, issue;
        logic [ADDR_W-1:0] g_addr;
        logic [DATA_W-1:0] g_data;
        logic              x_av, x_bv, x_ae, x_be;
        logic [DATA_W-1:0] x_ad, x_bd;

        a_req = ar; a_we = aw; a_addr = aa; a_wdata = ad;
        b_req = br; b_we = bw; b_addr = ba; b_wdata = bd;
        rst_n = rst;

        @(negedge clk);
        eg_a = 1'b0;
        eg_b = 1'b0;
        if (rst_n) begin
            if (ar && br) begin
                if (streak == MAX_CONSEC) eg_b = 1'b1;
                else                      eg_a = 1'b1;
            end else begin
                eg_a = ar;
                eg_b = br;
            end
        end
        g_we   = eg_a ? aw : bw;
        g_addr = eg_a ? aa : ba;
        g_data = eg_a ? ad : bd;
        inr    = (g_addr < 48'(MEM_WORDS));
        issue  = (eg_a || eg_b) && inr;

        chk("a_gnt", 64'(a_gnt), 64'(eg_a));
        chk("b_gnt", 64'(b_gnt), 64'(eg_b));
        chk("one_grant", 64'(a_gnt & b_gnt), 64'd0);
        chk("mem_read", 64'(mem_read), 64'(issue && !g_we));
        chk("mem_write", 64'(mem_write), 64'(issue && g_we));
        chk("mem_address", 64'(mem_address), issue ? 64'(g_addr) : 64'd0);
        chk("mem_write_data", mem_write_data, issue ? g_data : 64'd0);
        if (!rst_n) begin
            chk("a_rdata_in_rst", a_rdata, 64'd0);
            chk("b_rdata_in_rst", b_rdata, 64'd0);
        end
        b_gnt_seen += int'(b_gnt);

        // reset asserted after the grant was seen but before the edge that would issue it
        if (rst_mid) rst_n = 1'b0;

        x_av = 1'b0; x_bv = 1'b0; x_ae = 1'b0; x_be = 1'b0;
        x_ad = '0;   x_bd = '0;
        if (!rst_n) begin
            streak = 0;
        end else begin
            if ((eg_a || eg_b) && !g_we && inr) begin
                if (eg_a) x_ad = ref_mem[g_addr[7:0]];
                else      x_bd = ref_mem[g_addr[7:0]];
            end
            if ((eg_a || eg_b) && g_we && inr) ref_mem[g_addr[7:0]] = g_data;
            x_av = eg_a && !g_we;
            x_bv = eg_b && !g_we;
            x_ae = eg_a && !inr;
            x_be = eg_b && !inr;
            if (eg_a && br) streak = (streak < MAX_CONSEC) ? streak + 1 : MAX_CONSEC;
            else            streak = 0;
        end

        @(posedge clk);
        #1;
        chk("a_rvalid", 64'(a_rvalid), 64'(x_av));
        chk("b_rvalid", 64'(b_rvalid), 64'(x_bv));
        chk("a_err", 64'(a_err), 64'(x_ae));
        chk("b_err", 64'(b_err), 64'(x_be));
        chk("a_rdata", a_rdata, x_ad);
        chk("b_rdata", b_rdata, x_bd);
    endtask

    task automatic idle(input logic rst);
        step(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0, rst, 1'b0);
    endtask

    initial begin
        int mism;
        int b0;
        n_assert = 0;
        n_fail = 0;
        streak = 0;
        b_gnt_seen = 0;
        for (int i = 0; i < MEM_WORDS; i++) ref_mem[i] = 64'(i);

        a_req = 0; a_we = 0; a_addr = '0; a_wdata = '0;
        b_req = 0; b_we = 0; b_addr = '0; b_wdata = '0;
        rst_n = 0;
        @(posedge clk);
        #1;

        idle(1'b0);
        idle(1'b0);
        idle(1'b1);

        // single A read of address 5
        step(1, 0, 48'd5, '0, 0, 0, '0, '0, 1, 0);
        chk("a_rdata_addr5", a_rdata, 64'd5);

        // write then immediate read-back on A
        step(1, 1, 48'd10, 64'hDEAD_BEEF, 0, 0, '0, '0, 1, 0);
        step(1, 0, 48'd10, '0, 0, 0, '0, '0, 1, 0);
        chk("a_rdata_raw", a_rdata, 64'hDEAD_BEEF);

        // both requesters saturating: B must win every fifth cycle
        idle(1'b1);
        b0 = b_gnt_seen;
        for (int i = 0; i < 10; i++)
            step(1, 0, 48'(i), '0, 1, 0, 48'(100 + i), '0, 1, 0);
        chk("b_share_10cyc", 64'(b_gnt_seen - b0), 64'd2);

        // out-of-range B read and A write
        step(0, 0, '0, '0, 1, 0, 48'd300, '0, 1, 0);
        step(1, 1, 48'h1_0000_0000, 64'h1234, 0, 0, '0, '0, 1, 0);

        // A read granted, reset lands on the issuing edge
        step(1, 0, 48'd7, '0, 0, 0, '0, '0, 1, 1);
        idle(1'b0);
        idle(1'b1);
        step(1, 0, 48'd7, '0, 0, 0, '0, '0, 1, 0);
        chk("a_rdata_addr7", a_rdata, 64'd7);

        // alternating A/B reads, no bubbles
        for (int i = 0; i < 6; i++) begin
            if (i % 2 == 0) step(1, 0, 48'd1, '0, 0, 0, '0, '0, 1, 0);
            else            step(0, 0, '0, '0, 1, 0, 48'd2, '0, 1, 0);
        end

        // simultaneous writes to the same word: A first, then B overwrites
        step(1, 1, 48'd20, 64'hAAAA, 1, 1, 48'd20, 64'hBBBB, 1, 0);
        step(0, 0, '0, '0, 1, 1, 48'd20, 64'hBBBB, 1, 0);
        step(1, 0, 48'd20, '0, 0, 0, '0, '0, 1, 0);
        chk("last_writer", a_rdata, 64'hBBBB);

        // random traffic
        for (int i = 0; i < 400; i++) begin
            logic [ADDR_W-1:0] ra, rb;
            logic              rs, rm;
            ra = ($urandom_range(0, 9) == 0) ? 48'(256 + $urandom_range(0, 200))
                                             : 48'($urandom_range(0, 15));
            rb = ($urandom_range(0, 9) == 0) ? 48'(256 + $urandom_range(0, 200))
                                             : 48'($urandom_range(0, 15));
            rs = ($urandom_range(0, 59) != 0);
            rm = ($urandom_range(0, 59) == 0);
            step(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)), ra,
                 {$urandom, $urandom},
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), rb,
                 {$urandom, $urandom}, rs, rm);
        end
        idle(1'b1);

        mism = 0;
        for (int i = 0; i < MEM_WORDS; i++)
            if (bus_mem[i] !== ref_mem[i]) mism++;
        chk("memory_contents", 64'(mism), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
